// File: rtl/bram_port_arbiter.sv
// Per-cycle arbiter sharing BRAM port A between the CPU data bus and the debug loader.
// CPU has default priority; a starvation counter and a debug burst lock bound debug latency.
module bram_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH/8-1:0] cpu_we,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    output logic                    cpu_gnt,
    output logic                    cpu_stall,
    output logic                    cpu_rvalid,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    input  logic                    dbg_req,
    input  logic                    dbg_lock,
    input  logic [ADDR_WIDTH-1:0]   dbg_addr,
    input  logic [DATA_WIDTH/8-1:0] dbg_we,
    input  logic [DATA_WIDTH-1:0]   dbg_wdata,
    output logic                    dbg_gnt,
    output logic                    dbg_rvalid,
    output logic [DATA_WIDTH-1:0]   dbg_rdata,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);
    localparam logic [7:0]            MAX_W      = 8'(MAX_WAIT);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    typedef enum logic {ARB, LOCK} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_t;

    state_t                  state_q, state_d;
    owner_t                  rd_owner_q, rd_owner_d;
    logic [7:0]              wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic                    cpu_req_m, dbg_req_m, locked;

    always_comb begin
        // Requests are masked during reset so grants and the memory mux sit at their idle values.
        cpu_req_m = cpu_req & ~rst;
        dbg_req_m = dbg_req & ~rst;
        // A dropped lock is arbitrated as shared in the same cycle.
        locked    = (state_q == LOCK) && dbg_lock;

        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (locked) begin
            dbg_gnt = dbg_req_m;
        end else if (cpu_req_m && dbg_req_m) begin
            if (wait_cnt_q == MAX_W) dbg_gnt = 1'b1;
            else                     cpu_gnt = 1'b1;
        end else begin
            cpu_gnt = cpu_req_m;
            dbg_gnt = dbg_req_m;
        end
        cpu_stall = cpu_req & ~cpu_gnt;

        mem_addr  = addr_q;
        mem_we    = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr & ALIGN_MASK;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_addr  = dbg_addr & ALIGN_MASK;
            mem_we    = dbg_we;
            mem_wdata = dbg_wdata;
        end
        addr_d = mem_addr;

        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (!locked) begin
            state_d = (dbg_gnt && dbg_lock) ? LOCK : ARB;
            if (!dbg_req_m || dbg_gnt)  wait_cnt_d = '0;
            else if (wait_cnt_q != MAX_W) wait_cnt_d = wait_cnt_q + 8'd1;
        end

        rd_owner_d = OWN_NONE;
        if (cpu_gnt && cpu_we == '0)      rd_owner_d = OWN_CPU;
        else if (dbg_gnt && dbg_we == '0) rd_owner_d = OWN_DBG;

        cpu_rvalid  = (rd_owner_q == OWN_CPU);
        dbg_rvalid  = (rd_owner_q == OWN_DBG);
        cpu_rdata_d = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        dbg_rdata_d = dbg_rvalid ? mem_rdata : dbg_rdata_q;
        // The BRAM output is live only in the return cycle; afterwards the captured copy holds.
        cpu_rdata   = cpu_rdata_d;
        dbg_rdata   = dbg_rdata_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB;
            rd_owner_q  <= OWN_NONE;
            wait_cnt_q  <= '0;
            addr_q      <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_owner_q  <= rd_owner_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_q      <= addr_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: a per-cycle reference model predicts grants and
// memory-side outputs, and queues the read data each requester should see.
module tb_bram_port_arbiter;
    localparam int AW = 16, DW = 32, WW = 4, MAXW = 8;

    logic clk = 1'b0, rst = 1'b1;
    logic cpu_req = 0, dbg_req = 0, dbg_lock = 0;
    logic [AW-1:0] cpu_addr = '0, dbg_addr = '0, mem_addr;
    logic [WW-1:0] cpu_we = '0, dbg_we = '0, mem_we;
    logic [DW-1:0] cpu_wdata = '0, dbg_wdata = '0, mem_wdata, mem_rdata = '0;
    logic cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [DW-1:0] cpu_rdata, dbg_rdata;

    always #5 clk = ~clk;

    bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr), .dbg_we(dbg_we),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct { int due; logic [DW-1:0] data; } rd_t;
    rd_t cpu_q[$], dbg_q[$];

    int checks = 0, errors = 0, cyc = 0, dbg_pulses = 0;
    logic [DW-1:0] cpu_last = '0, dbg_last = '0, nxt_rd = '0, forced_rd = '0;
    bit force_rd = 0;
    bit m_lock = 0;
    int m_wait = 0;
    logic [AW-1:0] m_last = '0;

    logic s_creq = 0, s_dreq = 0, s_dlock = 0;
    logic [AW-1:0] s_caddr = '0, s_daddr = '0;
    logic [WW-1:0] s_cwe = '0, s_dwe = '0;
    logic [DW-1:0] s_cwd = '0, s_dwd = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_cpu(input logic req, input logic [AW-1:0] a, input logic [WW-1:0] we,
                           input logic [DW-1:0] wd);
        s_creq = req; s_caddr = a; s_cwe = we; s_cwd = wd;
    endtask

    task automatic set_dbg(input logic req, input logic lk, input logic [AW-1:0] a,
                           input logic [WW-1:0] we, input logic [DW-1:0] wd);
        s_dreq = req; s_dlock = lk; s_daddr = a; s_dwe = we; s_dwd = wd;
    endtask

    // One clock cycle: apply stimulus, predict and compare the combinational outputs, advance the model.
    task automatic step();
        bit gc, gd, lk;
        logic [AW-1:0] ea;
        logic [WW-1:0] ew;
        logic [DW-1:0] ed;
        @(posedge clk); #1;
        cyc++;
        cpu_req = s_creq; cpu_addr = s_caddr; cpu_we = s_cwe; cpu_wdata = s_cwd;
        dbg_req = s_dreq; dbg_lock = s_dlock; dbg_addr = s_daddr; dbg_we = s_dwe; dbg_wdata = s_dwd;
        mem_rdata = nxt_rd;
        #3;
        lk = m_lock && dbg_lock;
        if (lk) begin
            gd = dbg_req; gc = 0;
        end else if (cpu_req && dbg_req) begin
            gd = (m_wait >= MAXW); gc = !gd;
        end else begin
            gc = cpu_req; gd = dbg_req;
        end
        ea = m_last; ew = '0; ed = '0;
        if (gc) begin
            ea = {cpu_addr[AW-1:2], 2'b00}; ew = cpu_we; ed = cpu_wdata;
        end else if (gd) begin
            ea = {dbg_addr[AW-1:2], 2'b00}; ew = dbg_we; ed = dbg_wdata;
        end
        chk("cpu_gnt", 64'(cpu_gnt), 64'(gc));
        chk("dbg_gnt", 64'(dbg_gnt), 64'(gd));
        chk("cpu_stall", 64'(cpu_stall), 64'(cpu_req && !gc));
        chk("mem_addr", 64'(mem_addr), 64'(ea));
        chk("mem_we", 64'(mem_we), 64'(ew));
        chk("mem_wdata", 64'(mem_wdata), 64'(ed));
        nxt_rd = force_rd ? forced_rd : DW'($urandom);
        force_rd = 0;
        if (gc && cpu_we == '0) cpu_q.push_back('{cyc + 1, nxt_rd});
        if (gd && dbg_we == '0) dbg_q.push_back('{cyc + 1, nxt_rd});
        if (!lk) begin
            if (dbg_req && !gd) m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
            else                m_wait = 0;
            m_lock = gd && dbg_lock;
        end
        m_last = ea;
    endtask

    always @(negedge clk) begin
        bit ev;
        if (!rst) begin
            ev = (cpu_q.size() > 0) && (cpu_q[0].due == cyc);
            chk("cpu_rvalid", 64'(cpu_rvalid), 64'(ev));
            if (ev) begin
                cpu_last = cpu_q[0].data;
                cpu_q.delete(0);
            end
            chk("cpu_rdata", 64'(cpu_rdata), 64'(cpu_last));
            ev = (dbg_q.size() > 0) && (dbg_q[0].due == cyc);
            chk("dbg_rvalid", 64'(dbg_rvalid), 64'(ev));
            if (ev) begin
                dbg_last = dbg_q[0].data;
                dbg_q.delete(0);
            end
            chk("dbg_rdata", 64'(dbg_rdata), 64'(dbg_last));
            if (dbg_rvalid) dbg_pulses++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cpu_gnt"}, 64'(cpu_gnt), 64'(0));
        chk({tag, "_dbg_gnt"}, 64'(dbg_gnt), 64'(0));
        chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        chk({tag, "_cpu_rvalid"}, 64'(cpu_rvalid), 64'(0));
        chk({tag, "_dbg_rvalid"}, 64'(dbg_rvalid), 64'(0));
        chk({tag, "_cpu_rdata"}, 64'(cpu_rdata), 64'(0));
        chk({tag, "_dbg_rdata"}, 64'(dbg_rdata), 64'(0));
    endtask

    initial begin
        int cpu_run, first_dbg;
        #2;
        cpu_req = 1'b1; dbg_req = 1'b1;
        #1;
        check_reset_outputs("por");
        cpu_req = 1'b0; dbg_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // CPU-only read with a known BRAM response
        set_cpu(1, 16'h0010, 4'b0000, '0);
        forced_rd = 32'hDEADBEEF; force_rd = 1;
        step();
        set_cpu(0, '0, '0, '0);
        step();
        chk("t1_cpu_rdata", 64'(cpu_rdata), 64'(32'hDEADBEEF));
        chk("t1_cpu_rvalid", 64'(cpu_rvalid), 64'(1));
        chk("t1_dbg_rvalid", 64'(dbg_rvalid), 64'(0));

        // Both requesters held continuously: starvation counter forces debug on the 9th cycle
        set_cpu(1, 16'h0100, 4'b0000, '0);
        set_dbg(1, 0, 16'h0200, 4'b0000, '0);
        cpu_run = 0; first_dbg = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (dbg_gnt && first_dbg == 0) first_dbg = i;
            if (i == 10) chk("starve_cpu_again", 64'(cpu_gnt), 64'(1));
        end
        chk("starve_dbg_cycle", 64'(first_dbg), 64'(9));
        set_cpu(0, '0, '0, '0); set_dbg(0, 0, '0, '0, '0);
        step();

        // Locked debug burst: write then 4 reads while CPU waits
        set_dbg(1, 1, 16'h7FFC, 4'b1111, 32'h12345678);
        step();
        dbg_pulses = 0;
        set_cpu(1, 16'h0040, 4'b0000, '0);
        for (int i = 0; i < 4; i++) begin
            set_dbg(1, 1, AW'(16'h7FF0 + 4 * i), 4'b0000, '0);
            step();
            chk("lock_cpu_stall", 64'(cpu_stall), 64'(1));
        end
        set_dbg(0, 0, '0, '0, '0);
        step();
        chk("unlock_cpu_gnt", 64'(cpu_gnt), 64'(1));
        @(negedge clk); #1;
        chk("lock_dbg_pulses", 64'(dbg_pulses), 64'(4));
        set_cpu(0, '0, '0, '0);
        step();

        // Misaligned CPU write
        set_cpu(1, 16'h0013, 4'b1000, 32'hA5A5A5A5);
        step();
        chk("misalign_addr", 64'(mem_addr), 64'(16'h0010));
        chk("misalign_we", 64'(mem_we), 64'(4'b1000));
        set_cpu(0, '0, '0, '0);
        step();

        // Alternating CPU / debug reads
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin set_cpu(1, AW'(i * 8), '0, '0); set_dbg(0, 0, '0, '0, '0); end
            else            begin set_cpu(0, '0, '0, '0); set_dbg(1, 0, AW'(i * 8), '0, '0); end
            step();
        end
        set_cpu(0, '0, '0, '0); set_dbg(0, 0, '0, '0, '0);
        step();

        // Reset right after a granted CPU read: the return is dropped
        set_cpu(1, 16'h0020, 4'b0000, '0);
        step();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        cpu_q.delete(); dbg_q.delete();
        cpu_last = '0; dbg_last = '0; m_lock = 0; m_wait = 0; m_last = '0;
        set_cpu(0, '0, '0, '0);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_cpu($urandom_range(0, 9) < 6, AW'($urandom),
                    ($urandom_range(0, 1) == 0) ? 4'b0000 : WW'($urandom), DW'($urandom));
            if ($urandom_range(0, 4) == 0) s_dlock = ~s_dlock;
            set_dbg($urandom_range(0, 9) < 5, s_dlock, AW'($urandom),
                    ($urandom_range(0, 1) == 0) ? 4'b0000 : WW'($urandom), DW'($urandom));
            step();
        end
        set_cpu(0, '0, '0, '0); set_dbg(0, 0, '0, '0, '0);
        step();
        step();
        chk("cpu_q_drained", 64'(cpu_q.size()), 64'(0));
        chk("dbg_q_drained", 64'(dbg_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
